// File: rtl/riscv_pkg.sv
// Shared types for the RISC-V M-extension multiply/divide unit.
package riscv_pkg;

  localparam int RV_XLEN = 32;

  typedef logic [RV_XLEN-1:0] xlen_t;
  typedef logic [4:0]         reg_addr_t;

  // funct7 value that selects the M extension within OPCODE_OP
  localparam logic [6:0] OPCODE_OP_FUNCT7_MULDIV = 7'b0000001;

  // Operation encoding equals the RV32M funct3 field
  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_e;

endpackage

// File: rtl/riscv_div_iter.sv
// Restoring divider on unsigned magnitudes: one quotient bit per cycle,
// XLEN cycles after start; done_o is high during the final step cycle.
module riscv_div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            kill_i,
  input  logic            start_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            done_o,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o
);

  localparam int CW = $clog2(XLEN);

  logic            busy_q, busy_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   trial;

  assign done_o      = busy_q && (cnt_q == CW'(XLEN - 1));
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

  // Next state: load on start, otherwise one shift/trial-subtract per cycle
  always_comb begin
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    shifted = {rem_q, quo_q[XLEN-1]};
    trial   = shifted - {1'b0, dvs_q};
    if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      quo_d  = dividend_i;
      rem_d  = '0;
      dvs_d  = divisor_i;
    end else if (busy_q) begin
      // A clear borrow bit means the shifted remainder covered the divisor
      if (!trial[XLEN]) begin
        rem_d = trial[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_d = shifted[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b0};
      end
      cnt_d = cnt_q + CW'(1);
      if (done_o) busy_d = 1'b0;
    end
    if (kill_i) busy_d = 1'b0;
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
    end
  end

endmodule

// File: rtl/riscv_muldiv.sv
// RISC-V M-extension unit: iterative shift-add multiply (or single-cycle
// when FAST_MUL), iterative divide in riscv_div_iter, sign fix-up, and a
// one-cycle out_valid pulse. Corner cases bypass straight to DONE.
module riscv_muldiv
  import riscv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  mdu_op_e         in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  reg_addr_t       in_rd,
  input  logic            flush,
  output logic            out_valid,
  output logic [XLEN-1:0] out_result,
  output reg_addr_t       out_rd
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  mdu_op_e           op_q, op_d;
  reg_addr_t         rd_q, rd_d, out_rd_q, out_rd_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   mcand_q, mcand_d, result_q, result_d;
  logic [2*XLEN-1:0] prod_q, prod_d;

  logic a_sgn, b_sgn, a_neg, b_neg, in_is_div, div_zero, div_ovf, shortcut;
  logic accept, div_start, div_done, calc_last;
  logic [XLEN-1:0]   a_mag, b_mag, short_res, fast_res, quo, rem, div_pick, div_res, fix_res;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] prod_fix;

  assign in_ready   = (state_q == S_IDLE) && !rst;
  assign accept     = in_ready && in_valid && !flush;
  assign out_valid  = (state_q == S_DONE) && !flush && !rst;
  assign out_result = rst ? '0 : result_q;
  assign out_rd     = rst ? '0 : out_rd_q;

  // Request decode: signedness, magnitudes and the cases that skip CALC
  always_comb begin
    a_sgn     = (in_op == MDU_MULH) || (in_op == MDU_MULHSU) || (in_op == MDU_DIV) || (in_op == MDU_REM);
    b_sgn     = (in_op == MDU_MULH) || (in_op == MDU_DIV) || (in_op == MDU_REM);
    a_neg     = a_sgn && in_a[XLEN-1];
    b_neg     = b_sgn && in_b[XLEN-1];
    a_mag     = a_neg ? -in_a : in_a;
    b_mag     = b_neg ? -in_b : in_b;
    in_is_div = (in_op >= MDU_DIV);
    div_zero  = in_is_div && (in_b == '0);
    div_ovf   = ((in_op == MDU_DIV) || (in_op == MDU_REM)) &&
                (in_a == {1'b1, {(XLEN-1){1'b0}}}) && (in_b == '1);
    shortcut  = div_zero || div_ovf || (!in_is_div && FAST_MUL);
    if (div_zero)
      short_res = ((in_op == MDU_DIV) || (in_op == MDU_DIVU)) ? '1 : in_a;
    else if (div_ovf)
      short_res = (in_op == MDU_DIV) ? in_a : '0;
    else
      short_res = fast_res;
  end

  generate
    if (FAST_MUL) begin : g_fast_mul
      logic [2*XLEN-1:0] fa, fb, fp;
      assign fa = {{XLEN{a_sgn && in_a[XLEN-1]}}, in_a};
      assign fb = {{XLEN{b_sgn && in_b[XLEN-1]}}, in_b};
      assign fp = fa * fb;
      assign fast_res = (in_op == MDU_MUL) ? fp[XLEN-1:0] : fp[2*XLEN-1:XLEN];
    end else begin : g_iter_mul
      assign fast_res = '0;
    end
  endgenerate

  assign div_start = accept && in_is_div && !shortcut;

  riscv_div_iter #(.XLEN(XLEN)) u_div (
    .clk         (clk),
    .rst         (rst),
    .kill_i      (flush),
    .start_i     (div_start),
    .dividend_i  (a_mag),
    .divisor_i   (b_mag),
    .done_o      (div_done),
    .quotient_o  (quo),
    .remainder_o (rem)
  );

  // Datapath helpers: shift-add step and sign/word selection for FIX
  always_comb begin
    mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_fix  = neg_q ? -prod_q : prod_q;
    div_pick  = ((op_q == MDU_REM) || (op_q == MDU_REMU)) ? rem : quo;
    div_res   = neg_q ? -div_pick : div_pick;
    if (op_q >= MDU_DIV)
      fix_res = div_res;
    else if (op_q == MDU_MUL)
      fix_res = prod_fix[XLEN-1:0];
    else
      fix_res = prod_fix[2*XLEN-1:XLEN];
    calc_last = (op_q >= MDU_DIV) ? div_done : (cnt_q == CW'(XLEN - 1));
  end

  // FSM next state and datapath updates; flush overrides everything
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    rd_d     = rd_q;
    neg_d    = neg_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    result_d = result_q;
    out_rd_d = out_rd_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = in_op;
          rd_d    = in_rd;
          neg_d   = ((in_op == MDU_REM) || (in_op == MDU_REMU)) ? a_neg : (a_neg ^ b_neg);
          mcand_d = b_mag;
          prod_d  = {{XLEN{1'b0}}, a_mag};
          cnt_d   = '0;
          if (shortcut) begin
            state_d  = S_DONE;
            result_d = short_res;
            out_rd_d = in_rd;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + CW'(1);
        if (op_q < MDU_DIV) prod_d = {mul_sum, prod_q[XLEN-1:1]};
        if (calc_last) state_d = S_FIX;
      end
      S_FIX: begin
        state_d  = S_DONE;
        result_d = fix_res;
        out_rd_d = rd_q;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d  = S_IDLE;
      result_d = result_q;
      out_rd_d = out_rd_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= MDU_MUL;
      rd_q     <= '0;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      prod_q   <= '0;
      result_q <= '0;
      out_rd_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      neg_q    <= neg_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      result_q <= result_d;
      out_rd_q <= out_rd_d;
    end
  end

endmodule
